// File: rtl/mux_scan_capture.sv
// mux_scan_capture: drives the selects of an external 8:1 mux, holds each
// channel for DWELL cycles, samples the mux output on the last dwell cycle
// and presents the assembled 8-bit word on a valid/ready handshake.
// Optional build macro MAJORITY_VOTE_EN: take three samples per channel
// (dwell DWELL-3, DWELL-2, DWELL-1) and store their majority.
module mux_scan_capture #(
  parameter int DWELL = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       mux_out,
  output logic       S0,
  output logic       S1,
  output logic       S2,
  output logic [7:0] word,
  output logic       valid,
  input  logic       ready,
  output logic       busy
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

  localparam logic [7:0] LP_LAST = 8'(DWELL - 1);

  state_t     r_state;
  logic [2:0] r_chan;
  logic [7:0] r_dwell;
  logic [6:0] r_asm;
  logic [2:0] r_sel;
  logic [7:0] r_word;
  logic       r_valid;
  logic       r_busy;
  logic       w_bit;

`ifdef MAJORITY_VOTE_EN
  // The filter needs three distinct dwell cycles per channel.
  if (DWELL < 3 || DWELL > 255) begin : g_bad_dwell
    $error("mux_scan_capture: DWELL must be 3..255 with MAJORITY_VOTE_EN");
  end

  localparam logic [7:0] LP_SAMP_A = 8'(DWELL - 3);
  localparam logic [7:0] LP_SAMP_B = 8'(DWELL - 2);

  logic r_samp_a;
  logic r_samp_b;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  // Capture the two early samples of the current channel for the vote.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_samp_a <= 1'b0;
      r_samp_b <= 1'b0;
    end else if (r_state == ST_SCAN) begin
      if (r_dwell == LP_SAMP_A) r_samp_a <= mux_out;
      if (r_dwell == LP_SAMP_B) r_samp_b <= mux_out;
    end
  end

  assign w_bit = maj3(r_samp_a, r_samp_b, mux_out);
`else
  if (DWELL < 1 || DWELL > 255) begin : g_bad_dwell
    $error("mux_scan_capture: DWELL must be 1..255");
  end

  assign w_bit = mux_out;
`endif

  // Scan sequencer: channel/dwell counting, bit assembly and word handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_chan  <= 3'd0;
      r_dwell <= 8'd0;
      r_asm   <= 7'd0;
      r_sel   <= 3'd0;
      r_word  <= 8'h00;
      r_valid <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_state <= ST_SCAN;
            r_chan  <= 3'd0;
            r_dwell <= 8'd0;
            r_sel   <= 3'd0;
            r_busy  <= 1'b1;
          end
        end
        ST_SCAN: begin
          if (r_dwell == LP_LAST) begin
            r_dwell <= 8'd0;
            if (r_chan == 3'd7) begin
              // Last channel's bit goes straight into the word, skipping r_asm.
              r_word  <= {w_bit, r_asm};
              r_valid <= 1'b1;
              r_busy  <= 1'b0;
              r_sel   <= 3'd0;
              r_state <= ST_HOLD;
            end else begin
              r_asm[r_chan] <= w_bit;
              r_chan        <= r_chan + 3'd1;
              r_sel         <= r_chan + 3'd1;
            end
          end else begin
            r_dwell <= r_dwell + 8'd1;
          end
        end
        ST_HOLD: begin
          if (ready) begin
            r_valid <= 1'b0;
            if (start) begin
              // Back-to-back scan straight from the handshake cycle.
              r_state <= ST_SCAN;
              r_chan  <= 3'd0;
              r_dwell <= 8'd0;
              r_sel   <= 3'd0;
              r_busy  <= 1'b1;
            end else begin
              r_state <= ST_IDLE;
            end
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_valid <= 1'b0;
          r_busy  <= 1'b0;
          r_sel   <= 3'd0;
        end
      endcase
    end
  end

  assign S0    = r_sel[0];
  assign S1    = r_sel[1];
  assign S2    = r_sel[2];
  assign word  = r_word;
  assign valid = r_valid;
  assign busy  = r_busy;

endmodule

// File: tb/tb_mux_scan_capture.sv
// Testbench for mux_scan_capture: emulates the scanned 8:1 mux, runs directed
// scenarios and a randomized phase, and checks every cycle against a
// time-based model of the scan.
module tb_mux_scan_capture;

  localparam int DWELL = 4;

`ifdef MAJORITY_VOTE_EN
  localparam logic [7:0] GLITCH_EXP = 8'hA5;
`else
  localparam logic [7:0] GLITCH_EXP = 8'hAD;
`endif

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       mux_out;
  logic       S0, S1, S2;
  logic [7:0] word;
  logic       valid;
  logic       ready;
  logic       busy;

  logic [7:0] D;
  logic       glitch;

  int total = 0;
  int bad   = 0;
  bit run_chk = 0;

  // model state
  int         m_mode;
  int         m_t;
  logic [2:0] m_sel;
  logic [7:0] m_word;
  logic [7:0] m_bits;
  logic       m_valid;
  logic       m_busy;
  logic [7:0] h1, h2;

  mux_scan_capture #(.DWELL(DWELL)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .mux_out (mux_out),
    .S0      (S0),
    .S1      (S1),
    .S2      (S2),
    .word    (word),
    .valid   (valid),
    .ready   (ready),
    .busy    (busy)
  );

  // The external mux being scanned, with an optional glitch injected.
  assign mux_out = D[{S2, S1, S0}] ^ glitch;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: time since the start edge decides channel, sample edges and completion.
  always @(posedge clk or negedge rst_n) begin
    logic [7:0] eff;
    logic [7:0] vote;
    int         idx;
    if (!rst_n) begin
      m_mode = 0; m_t = 0; m_sel = 3'd0; m_word = 8'h00; m_bits = 8'h00;
      m_valid = 1'b0; m_busy = 1'b0; h1 = 8'h00; h2 = 8'h00;
    end else begin
      eff = D ^ {8{glitch}};
      case (m_mode)
        0: if (start) begin
          m_mode = 1; m_t = 0; m_sel = 3'd0; m_busy = 1'b1;
        end
        1: begin
          m_t++;
          if (m_t % DWELL == 0) begin
            idx  = m_t / DWELL - 1;
            vote = (h2 & h1) | (h2 & eff) | (h1 & eff);
`ifdef MAJORITY_VOTE_EN
            m_bits[idx] = vote[idx];
`else
            m_bits[idx] = eff[idx];
`endif
          end
          if (m_t == 8 * DWELL) begin
            m_mode = 2; m_valid = 1'b1; m_busy = 1'b0; m_sel = 3'd0; m_word = m_bits;
          end else begin
            m_sel = 3'(m_t / DWELL);
          end
        end
        default: if (ready) begin
          m_valid = 1'b0;
          if (start) begin
            m_mode = 1; m_t = 0; m_busy = 1'b1;
          end else begin
            m_mode = 0;
          end
        end
      endcase
      h2 = h1;
      h1 = eff;
    end
  end

  // Per-cycle comparison of all outputs against the model.
  always @(negedge clk) begin
    if (run_chk) begin
      total++;
      if ({S2, S1, S0, valid, busy, word} !== {m_sel, m_valid, m_busy, m_word}) begin
        bad++;
        $display("FAIL model t=%0t: sel=%0d valid=%0b busy=%0b word=%02h expected sel=%0d valid=%0b busy=%0b word=%02h",
                 $time, {S2, S1, S0}, valid, busy, word, m_sel, m_valid, m_busy, m_word);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
    end
  endtask

  task automatic wait_valid(input string name, input int exp_n);
    int n;
    n = 0;
    while (!valid && n < 200) begin
      tick();
      n++;
    end
    chk(name, n, exp_n);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b1; ready = 1'b0; D = 8'h00; glitch = 1'b0;
    #1;
    run_chk = 1;
    repeat (3) tick();
    // reset state with start held high
    chk("rst_sel", {S2, S1, S0}, 3'd0);
    chk("rst_word", word, 8'h00);
    chk("rst_valid", valid, 1'b0);
    chk("rst_busy", busy, 1'b0);
    start = 1'b0;
    rst_n = 1'b1;
    tick();

    // abort at channel 5
    D = 8'hFF;
    start = 1'b1; tick(); start = 1'b0;
    begin
      int n;
      n = 0;
      while ({S2, S1, S0} != 3'd5 && n < 100) begin tick(); n++; end
    end
    chk("abort_reach_ch5", {S2, S1, S0}, 3'd5);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_busy", busy, 1'b0);
    chk("abort_sel", {S2, S1, S0}, 3'd0);
    chk("abort_word", word, 8'h00);
    chk("abort_valid", valid, 1'b0);
    tick();
    rst_n = 1'b1;
    tick();

    // static pattern A5, full scan after abort
    D = 8'hA5;
    start = 1'b1; tick(); start = 1'b0;
    repeat (4) tick();
    chk("a5_sel_at_4", {S2, S1, S0}, 3'd1);
    wait_valid("a5_latency_rest", 8 * DWELL - 4);
    chk("a5_word", word, 8'hA5);

    // backpressure: hold for 10 cycles with start pulses ignored
    for (int i = 0; i < 10; i++) begin
      start = (i % 3 == 0);
      D = 8'(i * 37);
      tick();
    end
    start = 1'b0;
    chk("bp_valid", valid, 1'b1);
    chk("bp_word", word, 8'hA5);
    chk("bp_busy", busy, 1'b0);
    ready = 1'b1; tick(); ready = 1'b0;
    chk("bp_release", valid, 1'b0);
    tick();

    // back-to-back scans
    D = 8'h5A;
    start = 1'b1; tick(); start = 1'b0;
    wait_valid("b2b_first_latency", 8 * DWELL);
    chk("b2b_first_word", word, 8'h5A);
    D = 8'h3C;
    ready = 1'b1; start = 1'b1; tick(); ready = 1'b0; start = 1'b0;
    chk("b2b_busy", busy, 1'b1);
    chk("b2b_valid_low", valid, 1'b0);
    wait_valid("b2b_second_latency", 8 * DWELL);
    chk("b2b_second_word", word, 8'h3C);
    ready = 1'b1; tick(); ready = 1'b0;

    // one-cycle glitch on the last dwell cycle of channel 3
    D = 8'hA5;
    start = 1'b1; tick(); start = 1'b0;
    repeat (15) tick();
    glitch = 1'b1; tick(); glitch = 1'b0;
    wait_valid("glitch_latency_rest", 8 * DWELL - 16);
    chk("glitch_word", word, GLITCH_EXP);
    ready = 1'b1; tick(); ready = 1'b0;

    // randomized phase
    for (int i = 0; i < 1500; i++) begin
      D      = 8'($urandom);
      glitch = ($urandom_range(0, 7) == 0);
      start  = ($urandom_range(0, 3) == 0);
      ready  = ($urandom_range(0, 1) == 1);
      tick();
    end
    start = 1'b0; ready = 1'b0; glitch = 1'b0;
    tick();

    run_chk = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
